counter_monitor: RTL and testbench
==================================

COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 SHALL have parameter N_INIT, default 500, meaning the limit value the observed counter loads on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port selector  input  1  same selector the observed counter samples this cycle.
REQ-005 SHALL have port x_in  input  11  observed counter value x.
REQ-006 SHALL have port m_in  input  11  observed captured value m.
REQ-007 SHALL have port n_in  input  11  observed limit n.
REQ-008 SHALL have port err  output  1  sticky failure flag.
REQ-009 SHALL have port err_code  output  2  first failure cause: 0 none, 1 shadow mismatch, 2 invariant violation, 3 x decreased.
REQ-010 SHALL have port done  output  1  high while in DONE state.
REQ-011 SHALL have port steps  output  11  count of increments predicted, saturating at 2047.
REQ-012 SHALL have port hold_cnt  output  8  cycles spent in DONE, saturating at 255.

Function
REQ-013 SHALL keep shadow registers sx, sm, sn (11 bits each) modelling the observed counter.
REQ-014 SHALL implement FSM states RUN, DONE, FAIL; RUN is entered from reset.
REQ-015 SHALL, each non-reset cycle in RUN or DONE, compare (x_in, m_in, n_in) against (sx, sm, sn); any inequality is a mismatch (code 1).
REQ-016 SHALL flag invariant violation (code 2) when x_in >= n_in, n_in > 0 and m_in >= n_in, all unsigned.
REQ-017 SHALL flag x decrease (code 3) when x_in < previous cycle's x_in; not checked on the first cycle after reset.
REQ-018 SHALL, on simultaneous causes, record priority 2 over 3 over 1.
REQ-019 SHALL, on any cause, set err=1, latch err_code, and enter FAIL on the same edge.
REQ-020 SHALL, in FAIL, hold err, err_code, shadows, steps and hold_cnt frozen until rst; later causes do not overwrite err_code.
REQ-021 SHALL, when no cause and sx < sn: next sx = sx+1; next sm = sx if selector else sm; sn unchanged; steps += 1 (saturating).
REQ-022 SHALL, when no cause and sx >= sn, leave sx, sm, sn, steps unchanged.
REQ-023 SHALL move RUN -> DONE on the edge where no cause is flagged and x_in == n_in.
REQ-024 SHALL stay in DONE while no cause is flagged; hold_cnt increments each DONE cycle, saturating at 255; a cause moves DONE -> FAIL.
REQ-025 SHALL drive done = 1 only in DONE; done = 0 in RUN and FAIL.
REQ-026 SHALL use 11-bit unsigned arithmetic throughout; sx never wraps because increments stop at sx >= sn.
REQ-027 SHALL produce all outputs directly from registers (one-cycle latency from sampled inputs to err/err_code/done).

Reset
REQ-028 SHALL, on rst high at a posedge, set sx=0, sm=0, sn=N_INIT, state=RUN, err=0, err_code=0, done=0, steps=0, hold_cnt=0, and clear the previous-x register valid bit.
REQ-029 SHALL give rst priority over every other update, including from FAIL and mid-count.
REQ-030 SHALL perform no checks in a cycle where rst is high.

Verification
REQ-031 SHALL test: correct counter, selector=1 always -> after 500 increments sx=500, sm=499, done=1 next edge, err=0, steps=500.
REQ-032 SHALL test: correct counter, selector=0 always -> sm stays 0 through DONE; hold_cnt reaches 255 after 255+ DONE cycles and saturates.
REQ-033 SHALL test: force m_in=0 while model expects 7 (selector=1 at x=7) -> err=1, err_code=1 next edge; later faults leave code 1.
REQ-034 SHALL test: x_in=n_in=10, m_in=10 injected -> err_code=2 (overrides simultaneous mismatch).
REQ-035 SHALL test: x_in 5 then 4 with matching shadow forced -> err_code=3.
REQ-036 SHALL test: rst asserted in FAIL and at x=250 -> all outputs at reset values next edge; counting resumes from 0.

Source files
------------

// File: rtl/counter_monitor.sv
// Watches an external bounded counter (x, m, n) against internal shadow copies.
// Flags the first fault, classifies its cause, and tracks progress and hold time.
module counter_monitor #(
   parameter int unsigned N_INIT = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        selector,
   input  logic [10:0] x_in,
   input  logic [10:0] m_in,
   input  logic [10:0] n_in,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        done,
   output logic [10:0] steps,
   output logic [7:0]  hold_cnt
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_DONE = 2'd1,
      S_FAIL = 2'd2
   } state_t;

   localparam logic [10:0] N_RST = 11'(N_INIT);

   state_t      state_q, state_d;
   logic [10:0] sx_q, sx_d;
   logic [10:0] sm_q, sm_d;
   logic [10:0] sn_q, sn_d;
   logic [10:0] px_q, px_d;
   logic        pv_q, pv_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic        done_q, done_d;
   logic [10:0] steps_q, steps_d;
   logic [7:0]  hold_q, hold_d;

   logic        checking;
   logic        mis, inv, dec;
   logic        fail_now;
   logic [1:0]  cause;

   always_comb begin
      checking = (state_q != S_FAIL);
      mis      = (x_in != sx_q) || (m_in != sm_q) || (n_in != sn_q);
      inv      = (x_in >= n_in) && (n_in != 11'd0) && (m_in >= n_in);
      dec      = pv_q && (x_in < px_q);
      fail_now = checking && (mis || inv || dec);
      // Invariant beats decrease beats plain mismatch
      if (inv)      cause = 2'd2;
      else if (dec) cause = 2'd3;
      else if (mis) cause = 2'd1;
      else          cause = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         sx_q    <= 11'd0;
         sm_q    <= 11'd0;
         sn_q    <= N_RST;
         px_q    <= 11'd0;
         pv_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
         done_q  <= 1'b0;
         steps_q <= 11'd0;
         hold_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sm_q    <= sm_d;
         sn_q    <= sn_d;
         px_q    <= px_d;
         pv_q    <= pv_d;
         err_q   <= err_d;
         code_q  <= code_d;
         done_q  <= done_d;
         steps_q <= steps_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (fail_now)            state_d = S_FAIL;
            else if (x_in == n_in)   state_d = S_DONE;
         end
         S_DONE: begin
            if (fail_now)            state_d = S_FAIL;
         end
         default:                    state_d = S_FAIL;
      endcase
   end

   always_comb begin
      sx_d    = sx_q;
      sm_d    = sm_q;
      sn_d    = sn_q;
      px_d    = px_q;
      pv_d    = pv_q;
      err_d   = err_q;
      code_d  = code_q;
      steps_d = steps_q;
      hold_d  = hold_q;
      done_d  = (state_d == S_DONE);
      if (checking) begin
         px_d = x_in;
         pv_d = 1'b1;
         if (fail_now) begin
            err_d  = 1'b1;
            code_d = cause;
         end else begin
            if (sx_q < sn_q) begin
               sx_d = sx_q + 11'd1;
               if (selector) sm_d = sx_q;
               if (steps_q != 11'h7FF) steps_d = steps_q + 11'd1;
            end
            if (state_q == S_DONE && hold_q != 8'hFF)
               hold_d = hold_q + 8'd1;
         end
      end
   end

   assign err      = err_q;
   assign err_code = code_q;
   assign done     = done_q;
   assign steps    = steps_q;
   assign hold_cnt = hold_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: vector table plus long counting runs.
module tb_counter_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        selector;
   logic [10:0] x_in, m_in, n_in;
   logic        err;
   logic [1:0]  err_code;
   logic        done;
   logic [10:0] steps;
   logic [7:0]  hold_cnt;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   counter_monitor #(.N_INIT(500)) dut (
      .clk(clk), .rst(rst), .selector(selector),
      .x_in(x_in), .m_in(m_in), .n_in(n_in),
      .err(err), .err_code(err_code), .done(done),
      .steps(steps), .hold_cnt(hold_cnt)
   );

   typedef struct {
      logic        rst;
      logic        sel;
      logic [10:0] x, m, n;
      logic        err;
      logic [1:0]  code;
      logic        done;
      logic [10:0] steps;
      logic [7:0]  hold;
   } vec_t;

   vec_t tv[$];

   // observed-counter reference
   logic [10:0] cx, cm, cn;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input int x,
                      input int m, input int n, input logic e,
                      input int c, input logic d, input int st,
                      input int h);
      vec_t v;
      v.rst = r; v.sel = s;
      v.x = 11'(x); v.m = 11'(m); v.n = 11'(n);
      v.err = e; v.code = 2'(c); v.done = d;
      v.steps = 11'(st); v.hold = 8'(h);
      tv.push_back(v);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      x_in = 11'd0; m_in = 11'd0; n_in = 11'd500;
      tick();
      rst = 1'b0;
      cx = 11'd0; cm = 11'd0; cn = 11'd500;
   endtask

   // drive model values, clock, then advance the model
   task automatic count_step(input logic s);
      selector = s;
      x_in = cx; m_in = cm; n_in = cn;
      tick();
      if (cx < cn) begin
         if (s) cm = cx;
         cx = cx + 11'd1;
      end
   endtask

   initial begin
      rst = 1'b1; selector = 1'b0;
      x_in = '0; m_in = '0; n_in = 11'd500;

      // mismatch on m, then later fault must not overwrite code 1
      add(1,0,0,0,500, 0,0,0,0,0);
      add(0,1,0,0,500, 0,0,0,1,0);
      add(0,1,1,0,500, 0,0,0,2,0);
      add(0,1,2,1,500, 0,0,0,3,0);
      add(0,1,3,2,500, 0,0,0,4,0);
      add(0,1,4,3,500, 0,0,0,5,0);
      add(0,1,5,4,500, 0,0,0,6,0);
      add(0,1,6,5,500, 0,0,0,7,0);
      add(0,1,7,6,500, 0,0,0,8,0);
      add(0,1,8,0,500, 1,1,0,8,0);
      add(0,1,3,0,9,   1,1,0,8,0);
      // reset out of FAIL
      add(1,0,0,0,500, 0,0,0,0,0);
      add(0,0,0,0,500, 0,0,0,1,0);
      // invariant beats simultaneous mismatch
      add(0,0,10,10,10, 1,2,0,1,0);
      add(1,0,0,0,500, 0,0,0,0,0);
      // decrease beats simultaneous mismatch
      add(0,1,0,0,500, 0,0,0,1,0);
      add(0,1,1,0,500, 0,0,0,2,0);
      add(0,1,2,1,500, 0,0,0,3,0);
      add(0,1,3,2,500, 0,0,0,4,0);
      add(0,1,4,3,500, 0,0,0,5,0);
      add(0,1,5,4,500, 0,0,0,6,0);
      add(0,1,4,3,500, 1,3,0,6,0);
      add(1,0,0,0,500, 0,0,0,0,0);

      for (int i = 0; i < tv.size(); i++) begin
         rst = tv[i].rst; selector = tv[i].sel;
         x_in = tv[i].x; m_in = tv[i].m; n_in = tv[i].n;
         tick();
         chk($sformatf("v%0d err", i),   err,      tv[i].err);
         chk($sformatf("v%0d code", i),  err_code, tv[i].code);
         chk($sformatf("v%0d done", i),  done,     tv[i].done);
         chk($sformatf("v%0d steps", i), steps,    tv[i].steps);
         chk($sformatf("v%0d hold", i),  hold_cnt, tv[i].hold);
      end

      // full count, selector high
      do_reset();
      for (int i = 0; i < 500; i++) count_step(1'b1);
      chk("sel1 steps500", steps, 500);
      chk("sel1 not done yet", done, 0);
      chk("sel1 model m", cm, 499);
      count_step(1'b1);
      chk("sel1 done", done, 1);
      chk("sel1 err", err, 0);
      chk("sel1 steps held", steps, 500);
      chk("sel1 hold0", hold_cnt, 0);

      // full count, selector low, long DONE dwell
      do_reset();
      for (int i = 0; i < 501; i++) count_step(1'b0);
      chk("sel0 done", done, 1);
      for (int i = 0; i < 254; i++) count_step(1'b0);
      chk("sel0 hold254", hold_cnt, 254);
      count_step(1'b0);
      chk("sel0 hold255", hold_cnt, 255);
      for (int i = 0; i < 40; i++) count_step(1'b0);
      chk("sel0 hold sat", hold_cnt, 255);
      chk("sel0 err", err, 0);
      chk("sel0 still done", done, 1);
      // a fault from DONE goes to FAIL
      x_in = 11'd499; m_in = 11'd0; n_in = 11'd500;
      tick();
      chk("done->fail code", err_code, 3);
      chk("done->fail done", done, 0);
      chk("fail hold frozen", hold_cnt, 255);

      // reset mid-count at x=250
      do_reset();
      for (int i = 0; i < 250; i++) count_step(1'b1);
      chk("mid steps250", steps, 250);
      rst = 1'b1; x_in = 11'd250; m_in = 11'd249; n_in = 11'd500;
      tick();
      rst = 1'b0;
      chk("mid rst steps", steps, 0);
      chk("mid rst err", err, 0);
      chk("mid rst done", done, 0);
      cx = 11'd0; cm = 11'd0; cn = 11'd500;
      count_step(1'b1);
      count_step(1'b1);
      chk("resume steps", steps, 2);
      chk("resume err", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
